w_buf_loader: RTL and testbench

W_BUF_LOADER -- requirements
Module: w_buf_loader

---
 rtl/w_buf_loader.sv | 142 ++++++++++++++
 tb/tb_w_buf_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/w_buf_loader.sv
// Weight-buffer loader: gathers COL stream words into one packed row and writes
// row_cnt rows to consecutive buffer addresses, wrapping modulo DEPTH.
module w_buf_loader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int COL        = 10,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [ADDR_WIDTH:0]    row_cnt_i,
  input  logic                   s_valid_i,
  input  logic [WIDTH-1:0]       s_data_i,
  output logic                   s_ready_o,
  output logic                   wr_en_o,
  output logic [ADDR_WIDTH-1:0]  wr_addr_o,
  output logic [WIDTH*COL-1:0]   wr_data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int WW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = WIDTH * COL;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_row_idx;
  logic [WW-1:0]         r_word;
  logic [RW-1:0]         r_row;
  logic                  w_accept;
  logic                  w_last_word;
  logic                  w_last_row;
  logic                  w_write;
  logic [CW-1:0]         w_cnt_lim;

  assign w_accept    = (r_state == FILL) && s_valid_i;
  assign w_last_word = (r_word == WW'(COL - 1));
  assign w_last_row  = ((r_row_idx + CW'(1)) == r_cnt);
  assign w_cnt_lim   = (row_cnt_i > CW'(DEPTH)) ? CW'(DEPTH) : row_cnt_i;
  assign w_write     = (r_state == WRITE);

  // State register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next = (w_cnt_lim == {CW{1'b0}}) ? DONE : FILL;
        end else begin
          w_next = IDLE;
        end
      end
      FILL: begin
        if (w_accept && w_last_word) begin
          w_next = WRITE;
        end else begin
          w_next = FILL;
        end
      end
      WRITE: begin
        if (w_last_row) begin
          w_next = DONE;
        end else begin
          w_next = FILL;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Load parameters, word packing and row/address stepping
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_addr    <= {ADDR_WIDTH{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_row_idx <= {CW{1'b0}};
      r_word    <= {WW{1'b0}};
      r_row     <= {RW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_addr    <= base_addr_i;
            r_cnt     <= w_cnt_lim;
            r_row_idx <= {CW{1'b0}};
            r_word    <= {WW{1'b0}};
            r_row     <= {RW{1'b0}};
          end
        end
        FILL: begin
          if (w_accept) begin
            for (int k = 0; k < COL; k++) begin
              if (r_word == WW'(k)) begin
                r_row[k*WIDTH +: WIDTH] <= s_data_i;
              end
            end
            r_word <= w_last_word ? {WW{1'b0}} : (r_word + WW'(1));
          end
        end
        WRITE: begin
          r_row_idx <= r_row_idx + CW'(1);
          // Address wraps at DEPTH even when DEPTH is not a power of two
          r_addr    <= (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? {ADDR_WIDTH{1'b0}}
                                                         : (r_addr + ADDR_WIDTH'(1));
          r_word    <= {WW{1'b0}};
        end
        default: begin
        end
      endcase
    end
  end

  assign s_ready_o = (r_state == FILL);
  assign busy_o    = (r_state != IDLE);
  assign done_o    = (r_state == DONE);
  assign wr_en_o   = w_write;
  assign wr_addr_o = w_write ? r_addr : {ADDR_WIDTH{1'b0}};
  assign wr_data_o = w_write ? r_row : {RW{1'b0}};

endmodule

// File: tb/tb_w_buf_loader.sv
// Bench for w_buf_loader: table of load scenarios driven through a scoreboard,
// plus hand sequences for reset state and reset in the middle of a load.
module tb_w_buf_loader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int COL   = 10;
  localparam int AW    = 4;
  localparam int DW    = WIDTH * COL;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [AW-1:0]    base_addr_i;
  logic [AW:0]      row_cnt_i;
  logic             s_valid_i;
  logic [WIDTH-1:0] s_data_i;
  logic             s_ready_o;
  logic             wr_en_o;
  logic [AW-1:0]    wr_addr_o;
  logic [DW-1:0]    wr_data_o;
  logic             busy_o;
  logic             done_o;

  w_buf_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COL(COL), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .row_cnt_i(row_cnt_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(s_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  typedef struct {
    int base;
    int rows;
    int stall;      // 0 always valid, 1 toggling, 2 random
    bit bstart;     // pulse a conflicting start during FILL
    bit seqd;       // words 1..COL instead of random
    int exp_writes;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_writes = 0;
  int   n_done = 0;
  int   n_ready = 0;
  int   last_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitor: pops the scoreboard on every write strobe
  always @(negedge clk) begin
    exp_t e;
    if (wr_en_o === 1'b1) begin
      n_writes++;
      chk("ready_in_write", DW'(s_ready_o), DW'(0));
      if (sb.size() == 0) begin
        chk("unexpected_write", DW'(wr_en_o), DW'(0));
      end else begin
        e = sb.pop_front();
        chk("wr_addr", DW'(wr_addr_o), DW'(e.addr));
        chk("wr_data", wr_data_o, e.data);
        chk("wr_cycle", DW'(cyc), DW'(e.cyc));
      end
    end else begin
      chk("idle_addr_zero", DW'(wr_addr_o), DW'(0));
      chk("idle_data_zero", wr_data_o, DW'(0));
    end
    if (done_o === 1'b1) begin
      n_done++;
      last_done_cyc = cyc;
    end
    if (s_ready_o === 1'b1) n_ready++;
  end

  task automatic run_load(input vec_t v);
    int               nrows;
    int               wr0, d0, rdy0, exp_done, waits;
    bit               ok, acc, valid, tog, injected;
    logic [WIDTH-1:0] word;
    logic [DW-1:0]    row;
    exp_t             e;
    nrows = (v.rows > DEPTH) ? DEPTH : v.rows;
    wr0 = n_writes; d0 = n_done; rdy0 = n_ready;
    ok = 1'b1; tog = 1'b0; injected = 1'b0;
    start_i = 1'b1; base_addr_i = AW'(v.base); row_cnt_i = (AW+1)'(v.rows);
    @(posedge clk); #1;
    start_i = 1'b0;
    exp_done = cyc;
    for (int r = 0; r < nrows && ok; r++) begin
      row = '0;
      for (int k = 0; k < COL && ok; k++) begin
        word = v.seqd ? WIDTH'(k + 1) : WIDTH'($urandom);
        row[k*WIDTH +: WIDTH] = word;
        waits = 0;
        acc = 1'b0;
        while (!acc && waits < 64) begin
          case (v.stall)
            0:       valid = 1'b1;
            1:       begin tog = ~tog; valid = tog; end
            default: valid = 1'($urandom_range(0, 1));
          endcase
          s_valid_i = valid;
          s_data_i  = valid ? word : ~word;
          if (v.bstart && r == 0 && k == 3 && !injected) begin
            start_i = 1'b1; base_addr_i = AW'(9); row_cnt_i = (AW+1)'(5);
            injected = 1'b1;
          end
          acc = valid && (s_ready_o === 1'b1);
          @(posedge clk); #1;
          start_i = 1'b0;
          waits++;
        end
        if (!acc) begin
          chk("word_accept_timeout", DW'(acc), DW'(1));
          ok = 1'b0;
        end
      end
      if (ok) begin
        e.addr = AW'((v.base + r) % DEPTH);
        e.data = row;
        e.cyc  = cyc;
        sb.push_back(e);
        exp_done = cyc + 1;
      end
    end
    s_valid_i = 1'b0;
    for (int i = 0; i < 40 && n_done == d0; i++) @(negedge clk);
    @(posedge clk); #1;
    chk("done_count", DW'(n_done - d0), DW'(1));
    chk("done_cycle", DW'(last_done_cyc), DW'(exp_done));
    chk("write_count", DW'(n_writes - wr0), DW'(v.exp_writes));
    chk("sb_drained", DW'(sb.size()), DW'(0));
    chk("busy_after", DW'(busy_o), DW'(0));
    if (v.rows == 0) chk("ready_never_high", DW'(n_ready - rdy0), DW'(0));
    sb.delete();
  endtask

  initial begin
    vec_t vecs[7];
    int   w0;
    vecs[0] = '{base: 0,  rows: 1,  stall: 0, bstart: 1'b0, seqd: 1'b1, exp_writes: 1};
    vecs[1] = '{base: 0,  rows: 1,  stall: 1, bstart: 1'b0, seqd: 1'b1, exp_writes: 1};
    vecs[2] = '{base: 14, rows: 4,  stall: 0, bstart: 1'b0, seqd: 1'b0, exp_writes: 4};
    vecs[3] = '{base: 0,  rows: 0,  stall: 0, bstart: 1'b0, seqd: 1'b0, exp_writes: 0};
    vecs[4] = '{base: 3,  rows: 20, stall: 2, bstart: 1'b0, seqd: 1'b0, exp_writes: 16};
    vecs[5] = '{base: 4,  rows: 2,  stall: 0, bstart: 1'b1, seqd: 1'b0, exp_writes: 2};
    vecs[6] = '{base: 7,  rows: 3,  stall: 2, bstart: 1'b0, seqd: 1'b0, exp_writes: 3};

    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; row_cnt_i = '0;
    s_valid_i = 1'b0; s_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", DW'(s_ready_o), DW'(0));
    chk("rst_wr_en", DW'(wr_en_o), DW'(0));
    chk("rst_addr", DW'(wr_addr_o), DW'(0));
    chk("rst_data", wr_data_o, DW'(0));
    chk("rst_busy", DW'(busy_o), DW'(0));
    chk("rst_done", DW'(done_o), DW'(0));
    rst_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_load(vecs[i]);

    // Reset after five accepted words, with start asserted alongside reset
    w0 = n_writes;
    start_i = 1'b1; base_addr_i = AW'(5); row_cnt_i = (AW+1)'(2);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("midload_busy", DW'(busy_o), DW'(1));
    for (int k = 0; k < 5; k++) begin
      s_valid_i = 1'b1; s_data_i = WIDTH'($urandom);
      @(posedge clk); #1;
    end
    rst_i = 1'b1; start_i = 1'b1; s_valid_i = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", DW'(busy_o), DW'(0));
    chk("midrst_ready", DW'(s_ready_o), DW'(0));
    chk("midrst_wr_en", DW'(wr_en_o), DW'(0));
    chk("midrst_done", DW'(done_o), DW'(0));
    rst_i = 1'b0; start_i = 1'b0; s_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle", DW'(busy_o), DW'(0));
    chk("midrst_no_write", DW'(n_writes - w0), DW'(0));
    run_load('{base: 2, rows: 1, stall: 0, bstart: 1'b0, seqd: 1'b0, exp_writes: 1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
